// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: read-owner tags and the RAM read latency
// that sizes the response-routing pipeline.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam int RAM_RD_LATENCY = 1;
  localparam int TAG_STAGES     = RAM_RD_LATENCY + 1;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: LS priority with an IF
// anti-starvation streak limit, registered RAM command, owner-tagged read returns.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 256,
  parameter int STARVE_MAX = 3,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rd_dv,
  output logic [WIDTH-1:0]  o_if_rd_data,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [WIDTH-1:0]  i_ls_wr_data,
  output logic              o_ls_gnt,
  output logic              o_ls_rd_dv,
  output logic [WIDTH-1:0]  o_ls_rd_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_wr_dv,
  output logic [WIDTH-1:0]  o_ram_wr_data,
  output logic              o_ram_rd_en,
  input  logic              i_ram_rd_dv,
  input  logic [WIDTH-1:0]  i_ram_rd_data
);

  // A zero STARVE_MAX still needs a 1-bit counter; it simply never leaves 0.
  localparam int                  STREAK_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_MAX);
  localparam bit                  FAIR_EN    = (STARVE_MAX > 0);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                if_win;
  logic                if_gnt;
  logic                ls_gnt;
  logic                ls_rd;
  logic                ls_wr;
  owner_t              rd_owner;
  owner_t              tag [TAG_STAGES];

  always_comb begin
    if_win = i_if_req && (!i_ls_req || (FAIR_EN && (streak == STREAK_LIM)));
    if_gnt = i_rst_n && if_win;
    ls_gnt = i_rst_n && i_ls_req && !if_win;
    ls_rd  = ls_gnt && !i_ls_we;
    ls_wr  = ls_gnt && i_ls_we;
  end

  always_comb begin
    streak_nxt = streak;
    if (!i_if_req || if_gnt) begin
      streak_nxt = '0;
    end else if (ls_gnt && (streak != STREAK_LIM)) begin
      streak_nxt = streak + 1'b1;
    end
  end

  always_comb begin
    rd_owner = OWN_NONE;
    if (if_gnt) begin
      rd_owner = OWN_IF;
    end else if (ls_rd) begin
      rd_owner = OWN_LS;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      streak        <= '0;
      o_ram_addr    <= '0;
      o_ram_wr_data <= '0;
      o_ram_wr_dv   <= 1'b0;
      o_ram_rd_en   <= 1'b0;
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag[i] <= OWN_NONE;
      end
    end else begin
      streak      <= streak_nxt;
      o_ram_rd_en <= if_gnt || ls_rd;
      o_ram_wr_dv <= ls_wr;
      if (if_gnt) begin
        o_ram_addr <= i_if_addr;
      end else if (ls_gnt) begin
        o_ram_addr <= i_ls_addr;
      end
      if (ls_wr) begin
        o_ram_wr_data <= i_ls_wr_data;
      end
      tag[0] <= rd_owner;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_ls_gnt = ls_gnt;

  // Returns that arrive while reset is held belong to dropped reads.
  assign o_if_rd_dv   = i_rst_n && i_ram_rd_dv && (tag[TAG_STAGES-1] == OWN_IF);
  assign o_ls_rd_dv   = i_rst_n && i_ram_rd_dv && (tag[TAG_STAGES-1] == OWN_LS);
  assign o_if_rd_data = i_ram_rd_data;
  assign o_ls_rd_data = i_ram_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM behind the arbiter, a transaction-level
// model with a pending-response queue, directed scenarios and randomized traffic.
module tb_ram_port_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int SM    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [15:0]   ls_wr_data = '0;

  logic          o_if_gnt, o_if_rd_dv, o_ls_gnt, o_ls_rd_dv;
  logic [15:0]   o_if_rd_data, o_ls_rd_data, o_ram_wr_data;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_wr_dv, o_ram_rd_en;
  logic          ram_rd_dv = 1'b0;
  logic [15:0]   ram_rd_data = '0;

  logic          o_if_gnt0, o_if_rd_dv0, o_ls_gnt0, o_ls_rd_dv0;
  logic [15:0]   o_if_rd_data0, o_ls_rd_data0, o_ram_wr_data0;
  logic [AW-1:0] o_ram_addr0;
  logic          o_ram_wr_dv0, o_ram_rd_en0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rd_dv(o_if_rd_dv), .o_if_rd_data(o_if_rd_data),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wr_data(ls_wr_data),
    .o_ls_gnt(o_ls_gnt), .o_ls_rd_dv(o_ls_rd_dv), .o_ls_rd_data(o_ls_rd_data),
    .o_ram_addr(o_ram_addr), .o_ram_wr_dv(o_ram_wr_dv), .o_ram_wr_data(o_ram_wr_data),
    .o_ram_rd_en(o_ram_rd_en), .i_ram_rd_dv(ram_rd_dv), .i_ram_rd_data(ram_rd_data)
  );

  // Strict-priority instance: only its grant rule is observed.
  ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_MAX(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt0),
    .o_if_rd_dv(o_if_rd_dv0), .o_if_rd_data(o_if_rd_data0),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wr_data(ls_wr_data),
    .o_ls_gnt(o_ls_gnt0), .o_ls_rd_dv(o_ls_rd_dv0), .o_ls_rd_data(o_ls_rd_data0),
    .o_ram_addr(o_ram_addr0), .o_ram_wr_dv(o_ram_wr_dv0), .o_ram_wr_data(o_ram_wr_data0),
    .o_ram_rd_en(o_ram_rd_en0), .i_ram_rd_dv(1'b0), .i_ram_rd_data(16'h0000)
  );

  function automatic logic [15:0] init_val(int a);
    if (a == 16'h10) return 16'hBEEF;
    return 16'(a * 32'h0101) ^ 16'h5A5A;
  endfunction

  // Single-port RAM, 1-cycle read latency, no reset; preloaded on its first edge.
  logic [15:0] ram_mem [DEPTH];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (o_ram_wr_dv) begin
      ram_mem[o_ram_addr] <= o_ram_wr_data;
    end
    ram_rd_dv <= o_ram_rd_en;
    if (o_ram_rd_en) ram_rd_data <= ram_mem[o_ram_addr];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: memory contents as seen in program order,
  // outstanding reads as (due cycle, port, data) records.
  typedef struct packed {
    int          due;
    logic        is_ls;
    logic [15:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [15:0] m_mem [DEPTH];
  bit          m_init = 1'b0;
  int          cyc = 0;
  int          m_streak = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0] m_wr_data = '0;
  logic        m_wr_dv = 1'b0;
  logic        m_rd_en = 1'b0;

  always @(negedge clk) begin
    logic  e_if, e_ls, e_if_dv, e_ls_dv;
    logic [15:0] e_data;
    resp_t r;
    if (!m_init) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = init_val(i);
      m_init = 1'b1;
    end
    cyc++;

    e_if = 1'b0;
    e_ls = 1'b0;
    if (rst_n) begin
      if (if_req && (!ls_req || m_streak == SM)) e_if = 1'b1;
      else if (ls_req) e_ls = 1'b1;
    end
    check("if_gnt", 32'(o_if_gnt), 32'(e_if));
    check("ls_gnt", 32'(o_ls_gnt), 32'(e_ls));
    check("sm0_if_gnt", 32'(o_if_gnt0), 32'(rst_n && if_req && !ls_req));
    check("sm0_ls_gnt", 32'(o_ls_gnt0), 32'(rst_n && ls_req));

    check("ram_addr", 32'(o_ram_addr), 32'(m_addr));
    check("ram_wr_dv", 32'(o_ram_wr_dv), 32'(m_wr_dv));
    check("ram_rd_en", 32'(o_ram_rd_en), 32'(m_rd_en));
    check("ram_wr_data", 32'(o_ram_wr_data), 32'(m_wr_data));

    e_if_dv = 1'b0;
    e_ls_dv = 1'b0;
    e_data  = '0;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      e_if_dv = !r.is_ls;
      e_ls_dv = r.is_ls;
      e_data  = r.data;
    end
    if (!rst_n) begin
      e_if_dv = 1'b0;
      e_ls_dv = 1'b0;
    end
    check("if_rd_dv", 32'(o_if_rd_dv), 32'(e_if_dv));
    check("ls_rd_dv", 32'(o_ls_rd_dv), 32'(e_ls_dv));
    if (e_if_dv) check("if_rd_data", 32'(o_if_rd_data), 32'(e_data));
    if (e_ls_dv) check("ls_rd_data", 32'(o_ls_rd_data), 32'(e_data));

    // Advance the model by the edge that ends this cycle.
    if (!rst_n) begin
      pend.delete();
      m_streak  = 0;
      m_addr    = '0;
      m_wr_data = '0;
      m_wr_dv   = 1'b0;
      m_rd_en   = 1'b0;
    end else begin
      m_wr_dv = e_ls && ls_we;
      m_rd_en = e_if || (e_ls && !ls_we);
      if (e_if) begin
        m_addr = if_addr;
        r = '{due: cyc + 2, is_ls: 1'b0, data: m_mem[if_addr]};
        pend.push_back(r);
      end else if (e_ls) begin
        m_addr = ls_addr;
        if (ls_we) begin
          m_wr_data      = ls_wr_data;
          m_mem[ls_addr] = ls_wr_data;
        end else begin
          r = '{due: cyc + 2, is_ls: 1'b1, data: m_mem[ls_addr]};
          pend.push_back(r);
        end
      end
      if (!if_req || e_if) m_streak = 0;
      else if (e_ls && m_streak < SM) m_streak++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;
    int    npulse;
    logic  gi, gl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(o_ram_rd_en), 0);
    check("rst_wr_dv", 32'(o_ram_wr_dv), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // IF read of 0x10 with LS idle
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk); check("t1_if_gnt", 32'(o_if_gnt), 1);
    next_cycle(); if_req = 1'b0;
    @(negedge clk);
    check("t1_rd_en", 32'(o_ram_rd_en), 1);
    check("t1_addr", 32'(o_ram_addr), 'h10);
    next_cycle();
    @(negedge clk);
    check("t1_if_dv", 32'(o_if_rd_dv), 1);
    check("t1_if_data", 32'(o_if_rd_data), 'hBEEF);
    check("t1_ls_dv", 32'(o_ls_rd_dv), 0);

    // LS write 0x1234 to 0x05 then read it back
    next_cycle(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h05; ls_wr_data = 16'h1234;
    @(negedge clk); check("t2_if_dv_c0", 32'(o_if_rd_dv), 0);
    next_cycle(); ls_we = 1'b0;
    @(negedge clk);
    check("t2_wr_dv", 32'(o_ram_wr_dv), 1);
    check("t2_if_dv_c1", 32'(o_if_rd_dv), 0);
    next_cycle(); ls_req = 1'b0;
    @(negedge clk); check("t2_if_dv_c2", 32'(o_if_rd_dv), 0);
    next_cycle();
    @(negedge clk);
    check("t2_ls_dv", 32'(o_ls_rd_dv), 1);
    check("t2_ls_data", 32'(o_ls_rd_data), 'h1234);
    check("t2_if_dv_c3", 32'(o_if_rd_dv), 0);

    // Both requesting continuously: fairness pattern
    next_cycle();
    seq = "";
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if_req = 1'b1; if_addr = 8'(k);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'(k + 8);
      @(negedge clk);
      if (o_if_gnt) seq = {seq, "I"};
      else if (o_ls_gnt) seq = {seq, "L"};
      else seq = {seq, "-"};
    end
    n_checks++;
    if (seq != "LLLILLLI") begin
      n_errors++;
      $display("FAIL t3_grant_seq: got %s, expected LLLILLLI", seq);
    end
    next_cycle(); if_req = 1'b0; ls_req = 1'b0;
    repeat (3) next_cycle();

    // Reads granted in cycles 0 and 1, reset in cycle 2
    if_req = 1'b1; if_addr = 8'h11;
    @(negedge clk); check("t5_if_gnt", 32'(o_if_gnt), 1);
    next_cycle(); if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h05;
    @(negedge clk); check("t5_ls_gnt", 32'(o_ls_gnt), 1);
    next_cycle(); ls_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("t5_ram_dv_c2", 32'(ram_rd_dv), 1);
    check("t5_if_dv_c2", 32'(o_if_rd_dv), 0);
    check("t5_ls_dv_c2", 32'(o_ls_rd_dv), 0);
    next_cycle(); rst_n = 1'b1;
    @(negedge clk);
    check("t5_ram_dv_c3", 32'(ram_rd_dv), 1);
    check("t5_if_dv_c3", 32'(o_if_rd_dv), 0);
    check("t5_ls_dv_c3", 32'(o_ls_rd_dv), 0);
    check("t5_rd_en", 32'(o_ram_rd_en), 0);
    check("t5_wr_dv", 32'(o_ram_wr_dv), 0);
    check("t5_addr", 32'(o_ram_addr), 0);
    check("t5_wr_data", 32'(o_ram_wr_data), 0);
    next_cycle();
    @(negedge clk);
    check("t5_if_dv_c4", 32'(o_if_rd_dv), 0);
    check("t5_ls_dv_c4", 32'(o_ls_rd_dv), 0);

    // Back-to-back: IF rd A, LS wr B, LS rd B, IF rd A
    npulse = 0;
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      if_req = (k == 0 || k == 3); if_addr = 8'h10;
      ls_req = (k == 1 || k == 2); ls_we = (k == 1);
      ls_addr = 8'h20; ls_wr_data = 16'hCAFE;
      @(negedge clk);
      if (o_if_rd_dv) npulse++;
      if (o_ls_rd_dv) npulse++;
      if (k == 2) begin
        check("t6_if_dv_c2", 32'(o_if_rd_dv), 1);
        check("t6_if_data_c2", 32'(o_if_rd_data), 'hBEEF);
      end
      if (k == 4) begin
        check("t6_ls_dv_c4", 32'(o_ls_rd_dv), 1);
        check("t6_ls_data_c4", 32'(o_ls_rd_data), 'hCAFE);
      end
      if (k == 5) begin
        check("t6_if_dv_c5", 32'(o_if_rd_dv), 1);
        check("t6_if_data_c5", 32'(o_if_rd_data), 'hBEEF);
      end
    end
    check("t6_pulses", 32'(npulse), 3);

    // Randomized traffic with occasional resets; requests held until granted
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      gi = o_if_gnt;
      gl = o_ls_gnt;
      next_cycle();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
      if (!if_req || gi) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 8'($urandom_range(0, 31));
      end
      if (!ls_req || gl) begin
        ls_req     = ($urandom_range(0, 99) < 70);
        ls_we      = ($urandom_range(0, 99) < 40);
        ls_addr    = 8'($urandom_range(0, 31));
        ls_wr_data = 16'($urandom);
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    rst_n  = 1'b1;
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Sits directly upstream of the single-port RAM block and arbitrates two requesters onto its one shared address port.
  - Requester IF: instruction fetch, read-only.
  - Requester LS: load/store, read or write.
- Registers the winning command onto the RAM command inputs.
- Routes each RAM read response (fixed 1-cycle RAM latency, data-valid pulse) back to the requester that issued it.
- Fairness counter stops LS from starving IF indefinitely.

Parameters:
- WIDTH, 16, data width; must match the RAM WIDTH.
- DEPTH, 256, RAM depth; address width ADDR_W = $clog2(DEPTH).
- STARVE_MAX, 3, max consecutive LS grants while IF is waiting before IF is forced through; 0 = strict LS priority, no fairness.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_if_req  in  1  IF read request
- i_if_addr  in  ADDR_W  IF address
- o_if_gnt  out  1  IF request accepted this cycle (combinational)
- o_if_rd_dv  out  1  IF read data valid
- o_if_rd_data  out  WIDTH  IF read data
- i_ls_req  in  1  LS request
- i_ls_we  in  1  LS write (1) / read (0)
- i_ls_addr  in  ADDR_W  LS address
- i_ls_wr_data  in  WIDTH  LS write data
- o_ls_gnt  out  1  LS request accepted this cycle (combinational)
- o_ls_rd_dv  out  1  LS read data valid
- o_ls_rd_data  out  WIDTH  LS read data
- o_ram_addr  out  ADDR_W  registered RAM address
- o_ram_wr_dv  out  1  registered RAM write strobe
- o_ram_wr_data  out  WIDTH  registered RAM write data
- o_ram_rd_en  out  1  registered RAM read enable
- i_ram_rd_dv  in  1  RAM read data valid
- i_ram_rd_data  in  WIDTH  RAM read data

Behaviour:
- Handshake:
  - A request fires in cycle N when req and gnt are both high at the rising edge ending N.
  - A requester holds req, addr and data stable until it sees gnt.
  - At most one grant per cycle; IF and LS gnt are never high together.
- Arbitration (combinational from requests and streak counter):
  - LS wins by default.
  - IF wins if LS is not requesting, or if STARVE_MAX>0 and streak==STARVE_MAX.
- Streak counter, width $clog2(STARVE_MAX+1):
  - Increments on each LS grant while i_if_req is high.
  - Clears on any IF grant, or any cycle with i_if_req low.
  - Never exceeds STARVE_MAX.
- Command register, loaded at the end of cycle N:
  - On a grant: o_ram_addr = winner addr.
    - LS write: o_ram_wr_dv=1, o_ram_rd_en=0, o_ram_wr_data = i_ls_wr_data.
    - Any read: o_ram_rd_en=1, o_ram_wr_dv=0.
  - No grant: o_ram_wr_dv=0 and o_ram_rd_en=0; addr and wr_data hold their previous values.
- Owner tag pipeline, 2 stages, values NONE/IF/LS:
  - Stage 1 takes the read owner at the end of N.
  - Stage 2 takes stage 1 at the end of N+1.
  - Writes and idle cycles insert NONE.
- Response routing (combinational, cycle N+2):
  - o_if_rd_dv = i_ram_rd_dv & (tag2==IF); o_ls_rd_dv = i_ram_rd_dv & (tag2==LS).
  - Both rd_data outputs are driven from i_ram_rd_data at all times; only the dv qualifies them.
- Latency:
  - Read response appears exactly 2 cycles after the grant cycle.
  - Full throughput: one op per cycle, back-to-back, any mix.
- Ordering: same-address write in N followed by a read in N+1 returns the new data.
- Reset (i_rst_n low at an edge):
  - Streak counter = 0, tags = NONE, o_ram_wr_dv = 0, o_ram_rd_en = 0, o_ram_addr = 0, o_ram_wr_data = 0.
  - Grants are forced low while i_rst_n is low.
  - Reset mid-operation drops in-flight reads. Any i_ram_rd_dv arriving after reset (the RAM itself has no reset) is suppressed, because the tags are NONE.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_IF, OWN_LS};
  - localparam RAM_RD_LATENCY = 1, used to size the tag pipeline (RAM_RD_LATENCY+1 stages).
- No sub-module; the logic stays flat.
- The bench instantiates the RAM block behind the arbiter.

Test Plan:
- IF reads addr 0x10 with LS idle:
  - o_if_gnt=1 in cycle 0.
  - o_ram_rd_en=1 and o_ram_addr=0x10 in cycle 1.
  - o_if_rd_dv=1 with preloaded data 0xBEEF in cycle 2; o_ls_rd_dv stays 0.
- LS writes 0x1234 to 0x05 in cycle 0, LS reads 0x05 in cycle 1:
  - o_ram_wr_dv=1 in cycle 1.
  - o_ls_rd_dv=1 with data 0x1234 in cycle 3.
  - o_if_rd_dv stays 0 throughout.
- IF and LS both request continuously, STARVE_MAX=3:
  - Grant sequence LS,LS,LS,IF,LS,LS,LS,IF.
  - Each response is routed to its own port, 2 cycles after its grant.
- STARVE_MAX=0 under the same stimulus: IF is never granted while i_ls_req is high.
- Reads granted in cycles 0 and 1, i_rst_n low in cycle 2:
  - No o_if_rd_dv or o_ls_rd_dv in cycles 2–4, even though the RAM pulses i_ram_rd_dv.
  - All registered outputs read 0 after the reset edge.
- Back-to-back mix IF rd A, LS wr B, LS rd B, IF rd A over 4 cycles:
  - Exactly 3 dv pulses, in cycles 2, 4 and 5.
  - Each pulse lands on the correct port with the correct data.
